// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings,
// one-hot memory read codes and the sub-word byte-mask helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [4:0] RMEM_LB  = 5'b00001;
  localparam logic [4:0] RMEM_LH  = 5'b00010;
  localparam logic [4:0] RMEM_LW  = 5'b00100;
  localparam logic [4:0] RMEM_LBU = 5'b01000;
  localparam logic [4:0] RMEM_LHU = 5'b10000;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] mask_for(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_B, F3_BU: mask_for = 4'b0001 << off;
      F3_H, F3_HU: mask_for = 4'b0011 << off;
      default:     mask_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [4:0] rmem_code(input logic [2:0] funct3);
    case (funct3)
      F3_B:    rmem_code = RMEM_LB;
      F3_H:    rmem_code = RMEM_LH;
      F3_W:    rmem_code = RMEM_LW;
      F3_BU:   rmem_code = RMEM_LBU;
      F3_HU:   rmem_code = RMEM_LHU;
      default: rmem_code = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: extracts/extends a load lane from the read word and
// merges right-justified store data into the read word for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_load_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_load_ext,
  output logic [31:0] o_merged
);

  logic [31:0] w_shifted;
  logic [31:0] w_wshift;
  logic [31:0] w_bmask;

  assign w_shifted = i_load_data >> {i_off, 3'b000};
  assign w_wshift  = i_wdata << {i_off, 3'b000};
  assign w_bmask   = {{8{i_mask[3]}}, {8{i_mask[2]}}, {8{i_mask[1]}}, {8{i_mask[0]}}};
  assign o_merged  = (i_load_data & ~w_bmask) | (w_wshift & w_bmask);

  // NOTE: every branch of a combinational case must assign, or a latch is inferred;
  // the default arm covers the illegal encodings.
  always_comb begin
    case (i_funct3)
      F3_B:    o_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_load_ext = w_shifted;
      F3_BU:   o_load_ext = {24'h0, w_shifted[7:0]};
      F3_HU:   o_load_ext = {16'h0, w_shifted[15:0]};
      default: o_load_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request per handshake, checks it, drives the word
// memory port (sub-word stores as read-modify-write) and returns one response pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [3:0]  wmem,
  output logic [4:0]  rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  input  logic [31:0] load_data
);

  localparam logic [32:0] MEM_BYTES = 33'(1) << (ADDR_WIDTH + 2);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_word_idx;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_wbuf;

  logic        w_accept;
  logic [31:0] w_off;
  logic [31:0] w_word_idx;
  logic        w_in_range;
  logic        w_f3_legal;
  logic        w_misalign;
  logic        w_req_err;
  logic [3:0]  w_mask;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;

  assign req_ready  = (r_state == IDLE) && !rst;
  assign w_accept   = req_valid && req_ready;
  assign w_off      = req_addr - BASE_ADDR;
  assign w_word_idx = w_off >> 2;
  assign w_in_range = (req_addr >= BASE_ADDR) && ({1'b0, w_off} < MEM_BYTES);
  assign w_f3_legal = req_we ? (req_funct3 inside {F3_B, F3_H, F3_W})
                             : (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign w_misalign = ((req_funct3[1:0] == 2'd1) && req_addr[0])
                   || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
  assign w_req_err  = !w_in_range || w_misalign || !w_f3_legal;
  assign w_mask     = mask_for(r_funct3, r_off);

  lsu_align u_align (
    .i_load_data (load_data),
    .i_off       (r_off),
    .i_funct3    (r_funct3),
    .i_wdata     (r_wdata),
    .i_mask      (w_mask),
    .o_load_ext  (w_load_ext),
    .o_merged    (w_merged)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)                          w_state_next = RESP;
          else if (req_we && req_funct3 == F3_W) w_state_next = WR;
          else                                    w_state_next = RD;
        end
      end
      RD:      w_state_next = RD_WAIT;
      RD_WAIT: w_state_next = r_we ? WR : RESP;
      WR:      w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_wdata    <= 32'h0;
      r_word_idx <= 32'h0;
      r_err      <= 1'b0;
      r_rdata    <= 32'h0;
      r_wbuf     <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we       <= req_we;
        r_funct3   <= req_funct3;
        r_off      <= req_addr[1:0];
        r_wdata    <= req_wdata;
        r_word_idx <= w_word_idx;
        r_err      <= w_req_err;
        r_rdata    <= 32'h0;
      end
      if (r_state == RD_WAIT) begin
        if (r_we) r_wbuf  <= w_merged;
        else      r_rdata <= w_load_ext;
      end
    end
  end

  // Memory strobes are gated by rst so a reset in RD or WR never reaches memory.
  assign rmem       = (r_state == RD && !rst) ? (r_we ? RMEM_LW : rmem_code(r_funct3)) : 5'd0;
  assign wmem       = (r_state == WR && !rst) ? w_mask : 4'd0;
  assign store_data = (r_state == WR) ? ((r_funct3 == F3_W) ? r_wdata : r_wbuf) : 32'h0;
  assign mem_addr   = (r_state == IDLE) ? 32'h0 : r_word_idx;
  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid && r_err;
  assign resp_rdata = resp_valid ? r_rdata : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a synchronous word memory model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data = 32'h0;

  logic [31:0] mem [0:32767];
  int n_total = 0;
  int n_pass  = 0;

  lsu #(.ADDR_WIDTH(15), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .wmem       (wmem),
    .rmem       (rmem),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rmem != 5'd0) load_data <= mem[mem_addr[14:0]];
    if (wmem != 4'd0) mem[mem_addr[14:0]] <= store_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request at a negedge, accept it on the next posedge, drop it at the negedge after.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    check("ready_before_accept", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
  endtask

  // Error path: response in the first cycle after accept, no memory strobes.
  task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    issue(we, f3, addr, 32'h0);
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"},   32'(resp_err),   32'd1);
    check({tag, "_rdata"}, resp_rdata,      32'h0);
    check({tag, "_strb"},  {23'h0, rmem, wmem}, 32'h0);
    cyc();
    check({tag, "_idle"},  {30'h0, resp_valid, req_ready}, 32'd1);
  endtask

  // Load path: RD, RD_WAIT, RESP; checks rmem code, index and result.
  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] exp_rmem, input logic [31:0] exp_idx,
                           input logic [31:0] exp_data);
    issue(1'b0, f3, addr, 32'h0);
    check({tag, "_rmem"},  32'(rmem), 32'(exp_rmem));
    check({tag, "_maddr"}, mem_addr,  exp_idx);
    check({tag, "_rd_valid"}, 32'(resp_valid), 32'd0);
    cyc();
    check({tag, "_wait_strb"}, {23'h0, rmem, wmem}, 32'h0);
    cyc();
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"},   32'(resp_err),   32'd0);
    check({tag, "_rdata"}, resp_rdata,      exp_data);
    cyc();
    check({tag, "_after"}, {resp_valid, resp_rdata[30:0]}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    mem[0]     = 32'h8899_AABB;
    mem[1]     = 32'h1122_3344;
    mem[32767] = 32'h7F00_0000;

    @(negedge clk);
    req_valid = 1'b1;   // must be ignored while rst is high
    cyc();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_outs", {26'h0, resp_valid, resp_err, wmem != 4'd0, rmem != 5'd0, 2'b00}, 32'h0);
    check("rst_maddr", mem_addr, 32'h0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    cyc();
    check("post_rst_idle", {23'h0, rmem, wmem}, 32'h0);

    load_case("lb_sign",  3'd0, 32'h3, 5'b00001, 32'd0, 32'hFFFF_FF88);
    load_case("lhu_zero", 3'd5, 32'h2, 5'b10000, 32'd0, 32'h0000_8899);
    load_case("lh_sign",  3'd1, 32'h0, 5'b00010, 32'd0, 32'hFFFF_AABB);

    // SB read-modify-write into word 1, lane 1
    issue(1'b1, 3'd0, 32'h5, 32'h0000_0055);
    check("sb_rd_rmem", 32'(rmem), 32'(5'b00100));
    check("sb_rd_maddr", mem_addr, 32'd1);
    check("sb_rd_wmem", 32'(wmem), 32'd0);
    cyc();
    check("sb_wait_strb", {23'h0, rmem, wmem}, 32'h0);
    cyc();
    check("sb_wr_wmem", 32'(wmem), 32'(4'b0010));
    check("sb_wr_data", store_data, 32'h1122_5544);
    check("sb_wr_rmem", 32'(rmem), 32'd0);
    cyc();
    check("sb_resp", {resp_valid, resp_err, resp_rdata[29:0]}, 32'h8000_0000);
    cyc();
    load_case("lw_after_sb", 3'd2, 32'h4, 5'b00100, 32'd1, 32'h1122_5544);

    // SW: single WR cycle, no RD
    issue(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
    check("sw_wr_wmem", 32'(wmem), 32'hF);
    check("sw_wr_rmem", 32'(rmem), 32'd0);
    check("sw_wr_data", store_data, 32'hDEAD_BEEF);
    check("sw_wr_maddr", mem_addr, 32'd2);
    cyc();
    check("sw_resp", {resp_valid, resp_err, resp_rdata[29:0]}, 32'h8000_0000);
    cyc();
    load_case("lw_after_sw", 3'd2, 32'h8, 5'b00100, 32'd2, 32'hDEAD_BEEF);

    // SH into upper half of word 1
    issue(1'b1, 3'd1, 32'h6, 32'h0000_A1B2);
    cyc();
    cyc();
    check("sh_wr_wmem", 32'(wmem), 32'(4'b1100));
    check("sh_wr_data", store_data, 32'hA1B2_5544);
    cyc();
    check("sh_resp", 32'(resp_valid), 32'd1);
    cyc();

    err_case("lh_mis",  1'b0, 3'd1, 32'h1);
    err_case("sw_mis",  1'b1, 3'd2, 32'h6);
    err_case("lb_oor",  1'b0, 3'd0, 32'h0002_0000);
    err_case("ld_f3_3", 1'b0, 3'd3, 32'h0);
    err_case("st_f3_4", 1'b1, 3'd4, 32'h0);
    load_case("lb_top", 3'd0, 32'h0001_FFFF, 5'b00001, 32'd32767, 32'h0000_007F);

    // Reset asserted during WR of an SB: no write, no response
    issue(1'b1, 3'd0, 32'h0, 32'h0000_0011);
    cyc();
    cyc();
    check("rstwr_pre_wmem", 32'(wmem), 32'(4'b0001));
    rst = 1'b1;
    #1;
    check("rstwr_wmem", 32'(wmem), 32'd0);
    check("rstwr_ready", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("rstwr_no_resp", 32'(resp_valid), 32'd0);
    check("rstwr_ready_after", 32'(req_ready), 32'd1);
    check("rstwr_mem", mem[0], 32'h8899_AABB);
    cyc();
    check("rstwr_still_idle", {30'h0, resp_valid, req_ready}, 32'd1);
    load_case("lw_after_rst", 3'd2, 32'h0, 5'b00100, 32'd0, 32'h8899_AABB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the CPU-side initiator for the data memory port. It accepts one load or store per handshake from the execute stage, checks alignment and range, and drives the `wmem`/`rmem`/`mem_addr`/`store_data` word port. It extracts and sign/zero-extends load data, then returns one response pulse. The memory writes a whole word whenever `wmem != 0`, so the unit performs sub-word stores as a read-modify-write sequence.

## Interface
- `ADDR_WIDTH`, 15: word-address bits of data memory; memory covers `2**ADDR_WIDTH` words.
- `BASE_ADDR`, 32'h0000_0000: byte base of data memory; must be aligned to `4*2**ADDR_WIDTH`.
- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; a request is accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads use LB=0, LH=1, LW=2, LBU=4, LHU=5. Stores use SB=0, SH=1, SW=2.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle response pulse; there is no backpressure.
- `resp_rdata` out 32: extended load result; 0 for stores and errors.
- `resp_err` out 1: misaligned address, out-of-range address, or illegal funct3.
- `wmem` out 4: byte mask of the store; nonzero only in state WR.
- `rmem` out 5: one-hot load code (bit0 LB, bit1 LH, bit2 LW, bit3 LBU, bit4 LHU); nonzero only in state RD.
- `mem_addr` out 32: word index `(req_addr - BASE_ADDR) >> 2`, zero-extended.
- `store_data` out 32: full merged word to write.
- `load_data` in 32: word read; valid in the cycle after RD.

## Operation
- States are IDLE, RD, RD_WAIT, WR, RESP. `req_ready = (state == IDLE) && !rst`.
- On accept, the unit registers `we`, `funct3`, `addr` and `wdata`, then classifies the request:
  - **Error:** raised if the address is outside `[BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH)`, if a half access has `addr[0] != 0`, if a word access has `addr[1:0] != 0`, or if funct3 is illegal. Path: IDLE -> RESP with `resp_err = 1`. No memory access is made.
  - **Load:** IDLE -> RD -> RD_WAIT -> RESP. In RD, `rmem` carries the one-hot code. In RD_WAIT, the unit computes `load_data >> (8*addr[1:0])`, sign- or zero-extends it, and registers it into `resp_rdata`.
  - **SW:** IDLE -> WR -> RESP. In WR, `wmem = 4'hF` and `store_data = wdata`.
  - **SB/SH:** IDLE -> RD -> RD_WAIT -> WR -> RESP.
    - RD drives the LW code.
    - RD_WAIT merges the shifted `wdata` byte(s) into `load_data` under the byte mask and registers the result in `wbuf`.
    - WR drives `store_data = wbuf` and `wmem = mask`. SB uses `mask = 4'b0001 << addr[1:0]`; SH uses `4'b0011 << addr[1:0]`.
- In RESP, `resp_valid = 1`, then the next state is IDLE.
- `mem_addr` holds the registered word index from accept until the return to IDLE; it is 0 in IDLE.

## Timing
- Accept at edge E0 gives `resp_valid` high:
  - after E1 for an error;
  - after E2 for SW;
  - after E3 for a load;
  - after E4 for SB/SH.
- Minimum request spacing is latency + 1 cycles, because `req_ready` is low outside IDLE.
- The response pulse lasts exactly one cycle. `resp_rdata` and `resp_err` are valid only with `resp_valid`; they are 0 otherwise.
- Reset values: state IDLE; `resp_valid`, `resp_err` and `resp_rdata` 0; `wmem`, `rmem`, `mem_addr` and `store_data` 0; `req_ready` 0 while `rst = 1`.
- `wmem` and `rmem` are gated to 0 whenever `rst = 1`. Reset mid-operation, including in WR, therefore causes no memory write. The in-flight request is dropped and produces no response.
- `req_valid` arriving together with `rst` is ignored.
- At the top address `BASE_ADDR + 4*2**ADDR_WIDTH - 1`, LB is legal; at the top limit plus 1, LB sets `resp_err`.

## Structure
- Package `lsu_pkg` holds:
  - the state enum;
  - funct3 constants;
  - one-hot `rmem` constants;
  - a `mask_for(funct3, off)` function.
- Sub-module `lsu_align` is purely combinational. It covers load extraction/extension and store merge. It is shared by RD_WAIT for both load and RMW paths.

## Test plan
- **LB sign extension:** memory word 0 = 32'h8899_AABB. LB at addr 3 -> `rmem = 5'b00001`, `mem_addr = 0`, `resp_rdata = 32'hFFFF_FF88` three cycles after accept.
- **LHU zero extension:** LHU at addr 2 on the same word -> `resp_rdata = 32'h0000_8899`.
- **SB read-modify-write:** word 1 = 32'h1122_3344; SB `wdata = 32'h55` at addr 5. Required: an RD cycle, then a WR cycle with `wmem = 4'b0010` and `store_data = 32'h1122_5544`. A subsequent LW at addr 4 returns 32'h1122_5544.
- **SW:** SW `wdata = 32'hDEAD_BEEF` at addr 8 -> a single WR cycle with `wmem = 4'hF`, no RD cycle, `resp_valid` two cycles after accept.
- **Errors:** LH at addr 1, SW at addr 6, and LB at `4*2**ADDR_WIDTH` each give `resp_err = 1` one cycle after accept, with `wmem` and `rmem` 0 throughout.
- **Reset mid-store:** assert `rst` during the WR cycle of an SB -> `wmem` 0, memory unchanged, no `resp_valid`, `req_ready = 1` the cycle after `rst` falls.
